// File: rtl/event_encoder_83_pkg.sv
// -----------------------------------------------------------------------------
// encoder_pkg
// Shared constants and types for the event encoder: the number of event
// sources, the width of an event code, and the priority-select helper used
// to pick the highest-index pending source.
// No ports (package).
// -----------------------------------------------------------------------------
package encoder_pkg;

    localparam int EV_W    = 3;
    localparam int NUM_SRC = 8;

    typedef logic [EV_W-1:0] ev_code_t;

    // Index of the highest set bit; bit NUM_SRC-1 wins. Returns 0 for an
    // all-zero vector, so callers must qualify with a non-zero check.
    function automatic ev_code_t prio_index(input logic [NUM_SRC-1:0] vec);
        ev_code_t idx;
        idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (vec[i]) idx = ev_code_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/event_encoder_83_if.sv
// -----------------------------------------------------------------------------
// event_encoder_83_if
// Bundles the event encoder's request lines, consumer handshake, drop pulse
// and occupancy report.
//   req_i   : event request lines, one bit per source (bit 7 = top priority)
//   code_o  : code at the FIFO head (0 when empty)
//   valid_o : code_o holds a queued event
//   ready_i : consumer accepts code_o this cycle
//   drop_o  : one-cycle pulse when a duplicate event is lost
//   count_o : FIFO occupancy
// Modports: master = stimulus/consumer side, slave = encoder side.
// -----------------------------------------------------------------------------
interface event_encoder_83_if #(
    parameter int DEPTH = 4
) ();
    import encoder_pkg::*;

    logic [NUM_SRC-1:0]     req_i;
    ev_code_t               code_o;
    logic                   valid_o;
    logic                   ready_i;
    logic                   drop_o;
    logic [$clog2(DEPTH):0] count_o;

    modport master (
        output req_i, ready_i,
        input  code_o, valid_o, drop_o, count_o
    );

    modport slave (
        input  req_i, ready_i,
        output code_o, valid_o, drop_o, count_o
    );

endinterface

// File: rtl/event_encoder_83_fifo.sv
// -----------------------------------------------------------------------------
// code_fifo
// Circular FIFO of event codes with occupancy counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write data_i (ignored when full)
//   data_i     : event code to enqueue
//   pop_i      : remove head (ignored when empty, so count never underflows)
//   data_o     : head entry, forced to 0 when empty
//   count_o    : occupancy, 0..DEPTH
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module code_fifo
    import encoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  ev_code_t               data_i,
    input  logic                   pop_i,
    output ev_code_t               data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    ev_code_t      mem_q [DEPTH];
    logic          do_push, do_pop;
    logic          full, empty;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        do_push  = push_i && !full;
        do_pop   = pop_i && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only visible once
    // the counter says it was written, and the head output is masked to 0
    // while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full;
    assign empty_o = empty;

endmodule

// File: rtl/event_encoder_83.sv
// -----------------------------------------------------------------------------
// event_encoder_83
// Turns rising edges on eight request lines into a stream of 3-bit event
// codes. Each rising edge sets a sticky pending bit; every cycle the highest
// pending bit is pushed into a code FIFO if there is room. A second edge on a
// bit that is still pending (and not being pushed) is dropped and flagged on
// drop_o for one cycle.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset; clears all queued/pending events
//   ev    : event_encoder_83_if.slave (req_i, code_o, valid_o, ready_i,
//           drop_o, count_o)
// Configuration macro EVENT_INPUT_SYNC_EN: when defined, each req_i bit passes
// through a two-flop synchronizer before edge detection (latency 4 edges
// instead of 2).
// -----------------------------------------------------------------------------
module event_encoder_83
    import encoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    event_encoder_83_if.slave  ev
);

    logic [NUM_SRC-1:0] req_s;
    logic [NUM_SRC-1:0] req_q, req_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic               drop_q, drop_d;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] push_mask;
    ev_code_t           cand;
    logic               push;
    logic               full;
    logic               empty;

`ifdef EVENT_INPUT_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync1_d;
    logic [NUM_SRC-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = ev.req_i;
        sync2_d = sync1_q;
    end

    // Cleared with the rest of the state so a line held high through reset
    // still reads as a fresh rising edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = ev.req_i;
`endif

    always_comb begin
        req_d     = req_s;
        rise      = req_s & ~req_q;
        cand      = prio_index(pending_q);
        // Room is judged on the occupancy at the start of the cycle; a
        // same-cycle pop does not open a slot for a push.
        push      = (pending_q != '0) && !full;
        push_mask = '0;
        if (push) push_mask[cand] = 1'b1;
        // A new edge on the bit being pushed re-arms it for a later push.
        pending_d = (pending_q & ~push_mask) | rise;
        drop_d    = |(rise & pending_q & ~push_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            req_q     <= req_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    code_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (cand),
        .pop_i   (ev.ready_i),
        .data_o  (ev.code_o),
        .count_o (ev.count_o),
        .full_o  (full),
        .empty_o (empty)
    );

    assign ev.valid_o = !empty;
    assign ev.drop_o  = drop_q;

endmodule
